// File: rtl/gate_seq_ctrl.sv
// Self-checking stimulus sequencer for a 2-input gate: drives {a,b} = 00,01,10,11,
// waits SETTLE cycles, checks dut_x against EXP_TT. Optional: GATE_SEQ_FAILCAP_EN.
module gate_seq_ctrl #(
  parameter int unsigned SETTLE = 4,
  parameter logic [3:0]  EXP_TT = 4'b0110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_x,
  output logic       dut_a,
  output logic       dut_b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt
`ifdef GATE_SEQ_FAILCAP_EN
  ,
  output logic       fail_vld,
  output logic [1:0] fail_vec
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       dut_a_q, dut_b_q, busy_q, done_q, pass_q;
  logic [1:0] vec_q;
  logic [2:0] err_q;
  logic       mismatch;
  logic [2:0] err_d;
  logic [1:0] vec_d;
`ifdef GATE_SEQ_FAILCAP_EN
  logic       fail_vld_q;
  logic [1:0] fail_vec_q;
`endif

  // err_d folds in the current CHECK result so pass can see the final vector's outcome
  always_comb begin
    mismatch = (dut_x != EXP_TT[vec_q]);
    err_d    = err_q;
    if (mismatch && (err_q != 3'd4)) begin
      err_d = err_q + 3'd1;
    end
    vec_d = vec_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dut_a_q    <= 1'b0;
      dut_b_q    <= 1'b0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
`ifdef GATE_SEQ_FAILCAP_EN
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_DRIVE;
            busy_q     <= 1'b1;
            vec_q      <= '0;
            dut_a_q    <= 1'b0;
            dut_b_q    <= 1'b0;
            err_q      <= '0;
            pass_q     <= 1'b0;
`ifdef GATE_SEQ_FAILCAP_EN
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
`endif
          end
        end
        S_DRIVE: begin
          cnt_q   <= SETTLE_LD;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
`ifdef GATE_SEQ_FAILCAP_EN
          if (mismatch && !fail_vld_q) begin
            fail_vld_q <= 1'b1;
            fail_vec_q <= vec_q;
          end
`endif
          if (vec_q == 2'd3) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 3'd0);
          end else begin
            vec_q   <= vec_d;
            dut_a_q <= vec_d[1];
            dut_b_q <= vec_d[0];
            state_q <= S_DRIVE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_a   = dut_a_q;
  assign dut_b   = dut_b_q;
  assign vec_idx = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef GATE_SEQ_FAILCAP_EN
  assign fail_vld = fail_vld_q;
  assign fail_vec = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: default XOR instance plus an AND / SETTLE=1 instance.
module tb_gate_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start1, start2;
  logic       x1, a1, b1, busy1, done1, pass1;
  logic [1:0] vec1;
  logic [2:0] err1;
  logic       x2, a2, b2, busy2, done2, pass2;
  logic [1:0] vec2;
  logic [2:0] err2;
`ifdef GATE_SEQ_FAILCAP_EN
  logic       fv1, fv2;
  logic [1:0] fvec1, fvec2;
`endif
  int mdl;  // 0 XOR, 1 stuck-at-0, 2 XNOR
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gate_seq_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start1), .dut_x(x1),
    .dut_a(a1), .dut_b(b1), .vec_idx(vec1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_SEQ_FAILCAP_EN
    , .fail_vld(fv1), .fail_vec(fvec1)
`endif
  );

  gate_seq_ctrl #(.SETTLE(1), .EXP_TT(4'b1000)) u_and (
    .clk(clk), .reset(reset), .start(start2), .dut_x(x2),
    .dut_a(a2), .dut_b(b2), .vec_idx(vec2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GATE_SEQ_FAILCAP_EN
    , .fail_vld(fv2), .fail_vec(fvec2)
`endif
  );

  always_comb begin
    case (mdl)
      0:       x1 = a1 ^ b1;
      1:       x1 = 1'b0;
      default: x1 = ~(a1 ^ b1);
    endcase
    x2 = a2 & b2;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence on u_dut; optional start pulse at cycle inj_at after acceptance.
  task automatic do_run(input int inj_at, output int lat, output logic [7:0] seq,
                        output int ndone);
    int   n;
    int   abbad;
    logic [1:0] last;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("busy_after_accept", busy1, 1);
    chk("err_clr_on_accept", err1, 0);
    chk("pass_clr_on_accept", pass1, 0);
    n = 0; lat = -1; ndone = 0; abbad = 0;
    seq  = {6'd0, vec1};
    last = vec1;
    while (lat < 0 && n < 200) begin
      start1 = (n == inj_at);
      tick();
      n++;
      if (vec1 != last) begin
        seq  = {seq[5:0], vec1};
        last = vec1;
      end
      if (busy1 && ({a1, b1} != vec1)) abbad++;
      if (done1) begin
        ndone++;
        lat = n;
      end
    end
    start1 = 1'b0;
    chk("run_timeout", (lat < 0), 0);
    chk("ab_tracks_vec", abbad, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done1) ndone++;
    end
    chk("idle_after_run", busy1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, nd, n;
    logic [7:0] seq;
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; mdl = 0;
    tick(); tick();
    chk("rst_a", a1, 0);       chk("rst_b", b1, 0);
    chk("rst_vec", vec1, 0);   chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0); chk("rst_pass", pass1, 0);
    chk("rst_err", err1, 0);
`ifdef GATE_SEQ_FAILCAP_EN
    chk("rst_fvld", fv1, 0);   chk("rst_fvec", fvec1, 0);
`endif
    reset = 1'b0;
    tick();

    // 1: correct XOR
    mdl = 0;
    do_run(-1, lat, seq, nd);
    chk("t1_latency", lat, 24);
    chk("t1_ndone", nd, 1);
    chk("t1_seq", seq, 8'h1B);
    chk("t1_err", err1, 0);
    chk("t1_pass", pass1, 1);
    chk("t1_a_hold", a1, 1);
    chk("t1_b_hold", b1, 1);
`ifdef GATE_SEQ_FAILCAP_EN
    chk("t1_fvld", fv1, 0);
`endif

    // 2: stuck-at-0 fails vectors 01 and 10
    mdl = 1;
    do_run(-1, lat, seq, nd);
    chk("t2_err", err1, 2);
    chk("t2_pass", pass1, 0);
`ifdef GATE_SEQ_FAILCAP_EN
    chk("t2_fvld", fv1, 1);
    chk("t2_fvec", fvec1, 1);
`endif

    // 3: XNOR fails all four, then a clean rerun
    mdl = 2;
    do_run(-1, lat, seq, nd);
    chk("t3_err", err1, 4);
    chk("t3_pass", pass1, 0);
`ifdef GATE_SEQ_FAILCAP_EN
    chk("t3_fvec", fvec1, 0);
`endif
    mdl = 0;
    do_run(-1, lat, seq, nd);
    chk("t3_rerun_err", err1, 0);
    chk("t3_rerun_pass", pass1, 1);

    // 4: start pulse in SETTLE of vector 2 is ignored
    do_run(14, lat, seq, nd);
    chk("t4_latency", lat, 24);
    chk("t4_ndone", nd, 1);
    chk("t4_pass", pass1, 1);

    // 5: reset during CHECK of vector 1
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("t5_vec_pre", vec1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_a", a1, 0);       chk("t5_b", b1, 0);
    chk("t5_vec", vec1, 0);   chk("t5_busy", busy1, 0);
    chk("t5_done", done1, 0); chk("t5_pass", pass1, 0);
    chk("t5_err", err1, 0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done1 || busy1) nd++;
    end
    chk("t5_quiet", nd, 0);
    do_run(-1, lat, seq, nd);
    chk("t5_rerun_lat", lat, 24);
    chk("t5_rerun_seq", seq, 8'h1B);
    chk("t5_rerun_pass", pass1, 1);

    // 6: AND, SETTLE=1, start held high
    start2 = 1'b1;
    tick();
    chk("t6_busy", busy2, 1);
    n = 0; lat = -1;
    while (lat < 0 && n < 100) begin
      tick(); n++;
      if (done2) lat = n;
    end
    chk("t6_latency", lat, 12);
    chk("t6_pass", pass2, 1);
    chk("t6_err", err2, 0);
    tick(); n++;
    chk("t6_idle_gap", busy2, 0);
    tick(); n++;
    chk("t6_reaccept", busy2, 1);
    lat = -1;
    while (lat < 0 && n < 100) begin
      tick(); n++;
      if (done2) lat = n;
    end
    start2 = 1'b0;
    chk("t6_second_done", lat, 26);
    chk("t6_second_pass", pass2, 1);
    tick(); tick(); tick();
    chk("t6_stop", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gate_seq_ctrl.md
Name: gate_seq_ctrl

Overview:
Self-checking sequencer for a 2-input basic gate (my_xor2 style: inputs a, b, output x).
- On start, drives all four input vectors into the gate under test and waits a programmable settle time.
- Samples the gate output and compares it against a parameterised expected truth table.
- Reports the error count and pass/fail.
- Sits beside a gate instance in the lab top level, replacing hand-written timed stimulus.

Parameters:
- SETTLE, 4: cycles to wait after driving a vector before sampling dut_x. Legal range 1..15.
- EXP_TT, 4'b0110: expected truth table. Bit index = {a,b}, so the default is XOR.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a test run. Sampled only in IDLE.
- dut_x  input  1  output of the gate under test.
- dut_a  output  1  drive to gate input a (registered).
- dut_b  output  1  drive to gate input b (registered).
- vec_idx  output  2  current vector index; {dut_a,dut_b} == vec_idx while busy.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  high when the last run had zero errors. Held until the next accepted start.
- err_cnt  output  3  mismatches in the current/last run, 0..4.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values: dut_a=0, dut_b=0, vec_idx=0, busy=0, done=0, pass=0, err_cnt=0, state=IDLE, settle counter=0.
- States:
  - IDLE: busy=0. If start=1 → DRIVE. On that edge: vec_idx=0, dut_a=0, dut_b=0, err_cnt=0, pass=0.
  - DRIVE: 1 cycle. busy=1. Loads settle counter with SETTLE-1 → SETTLE.
  - SETTLE: counts down. At 0 → CHECK. Occupies exactly SETTLE cycles.
  - CHECK: 1 cycle. Samples dut_x and compares with EXP_TT[vec_idx]. On mismatch, err_cnt += 1 (saturates at 4; cannot exceed 4 by construction).
    - If vec_idx==3 → DONE.
    - Otherwise vec_idx += 1, dut_a/dut_b updated to the new index on the same edge, → DRIVE.
  - DONE: 1 cycle. done=1, busy=1. pass = (err_cnt==0), registered on the edge entering DONE. → IDLE.
- Vector order: 00, 01, 10, 11, i.e. dut_a = vec_idx[1], dut_b = vec_idx[0].
- Latency:
  - Each vector occupies SETTLE+2 cycles.
  - done is high in the cycle starting 4*(SETTLE+2) edges after the start-accepting edge (24 for SETTLE=4).
- start while busy (DRIVE/SETTLE/CHECK/DONE): ignored, no queuing.
- start held high continuously: a new run is accepted on the first IDLE cycle after DONE.
- reset mid-run: all registers return to reset values on that edge. No done pulse. pass=0.
- dut_x is sampled only in CHECK; its value in other states is don't-care.
- After a run, dut_a/dut_b stay at 1/1 (last vector) until the next start or reset.

Optional Feature:
- Macro: GATE_SEQ_FAILCAP_EN.
- Defined:
  - Adds outputs fail_vld (1) and fail_vec (2), both reset to 0 and cleared on start acceptance.
  - On the first CHECK mismatch of a run: fail_vld=1 and fail_vec=vec_idx.
  - Later mismatches in the same run do not overwrite the capture.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Correct XOR model on dut_x, SETTLE=4, pulse start → busy next cycle; done pulse exactly 24 edges after acceptance; err_cnt=0, pass=1; vectors observed 00, 01, 10, 11.
2. dut_x stuck at 0 → err_cnt=2 (vectors 01, 10), pass=0. With GATE_SEQ_FAILCAP_EN: fail_vld=1, fail_vec=2'b01.
3. XNOR model on dut_x → err_cnt=4, pass=0, no saturation overflow. Then a correct model on a rerun → err_cnt cleared to 0, pass=1.
4. start pulsed during SETTLE of vector 2 → ignored; exactly one done pulse; run length unchanged at 24 cycles.
5. reset asserted during CHECK of vector 1 → next cycle all outputs at reset values, no done pulse. A new start then runs the full sequence correctly.
6. EXP_TT=4'b1000 (AND) with an AND model, SETTLE=1 → done 12 edges after acceptance, pass=1. start held high → second run begins on the first IDLE cycle after DONE.
